// File: rtl/nec_ir_decoder_if.sv
// nec_ir_decoder_if -- bundle between the NEC IR decoder and its consumer.
//   i_IRDA        demodulated IR input (low = mark), asynchronous
//   i_DATA_ACK    consumer acknowledge
//   o_DATA        last accepted 32-bit frame, first received bit in bit 0
//   o_DATA_VALID  held high from frame acceptance until acknowledged
//   o_REPEAT      one-cycle pulse per accepted repeat code
//   o_ERROR       one-cycle pulse per aborted frame
//   o_OVERRUN     sticky overrun flag, cleared by acknowledge
// master: decoder side.  slave: consumer / stimulus side.
interface nec_ir_decoder_if;
  logic        i_IRDA;
  logic        i_DATA_ACK;
  logic [31:0] o_DATA;
  logic        o_DATA_VALID;
  logic        o_REPEAT;
  logic        o_ERROR;
  logic        o_OVERRUN;

  modport master (
    input  i_IRDA, i_DATA_ACK,
    output o_DATA, o_DATA_VALID, o_REPEAT, o_ERROR, o_OVERRUN
  );

  modport slave (
    output i_IRDA, i_DATA_ACK,
    input  o_DATA, o_DATA_VALID, o_REPEAT, o_ERROR, o_OVERRUN
  );
endinterface

// File: rtl/nec_ir_decoder.sv
// nec_ir_decoder -- NEC infrared frame decoder.
// Measures mark/space durations of the synchronised IR input in microseconds
// and checks each one against a +/-TOL_PCT window around its nominal length.
// Ports:
//   i_CLOCK_POS  system clock, rising edge
//   i_RESET_NEG  asynchronous active-low reset
//   ir           nec_ir_decoder_if.master (IR input, ack, frame/status outputs)
// Parameters: CLK_HZ (multiple of 1 MHz), TOL_PCT, TIMEOUT_US.
// Optional feature: define NEC_IR_CHECKSUM_EN to reject frames whose address
// and command bytes are not followed by their bitwise complements.
//
// state      | meaning
// IDLE       | waiting for a falling edge (start of lead mark)
// LEAD_MARK  | timing the 9000 us lead mark
// LEAD_SPACE | timing the lead space: 4500 us data, 2250 us repeat
// BIT_MARK   | timing a 560 us bit mark
// BIT_SPACE  | timing a bit space: 560 us = 0, 1690 us = 1
// TRAIL      | timing the 560 us trailing mark, then accept
module nec_ir_decoder #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TOL_PCT    = 20,
  parameter int TIMEOUT_US = 12_000
) (
  input  logic              i_CLOCK_POS,
  input  logic              i_RESET_NEG,
  nec_ir_decoder_if.master  ir
);

  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, TRAIL} state_t;

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LOAD = PW'(DIV - 1);

  function automatic int win_lo(input int nom);
    return nom - (nom * TOL_PCT) / 100;
  endfunction
  function automatic int win_hi(input int nom);
    return nom + (nom * TOL_PCT) / 100;
  endfunction

  localparam logic [13:0] LEAD_LO  = 14'(win_lo(9000));
  localparam logic [13:0] LEAD_HI  = 14'(win_hi(9000));
  localparam logic [13:0] DSPC_LO  = 14'(win_lo(4500));
  localparam logic [13:0] DSPC_HI  = 14'(win_hi(4500));
  localparam logic [13:0] RSPC_LO  = 14'(win_lo(2250));
  localparam logic [13:0] RSPC_HI  = 14'(win_hi(2250));
  localparam logic [13:0] SHORT_LO = 14'(win_lo(560));
  localparam logic [13:0] SHORT_HI = 14'(win_hi(560));
  localparam logic [13:0] ONE_LO   = 14'(win_lo(1690));
  localparam logic [13:0] ONE_HI   = 14'(win_hi(1690));
  localparam logic [13:0] TIMEOUT_CNT = 14'(TIMEOUT_US);

  function automatic logic in_win(input logic [13:0] d, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  logic          irda_s1_q, irda_s2_q, irda_prev_q;
  logic          rise_q, fall_q, edge_w;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0]   dur_q, dur_d;
  logic          timed_out;

  state_t        state_q;
  logic [4:0]    bit_idx_q;
  logic [31:0]   sr_q;
  logic          rep_flag_q;
  logic          seen_frame_q;
  logic [31:0]   data_q;
  logic          valid_q, repeat_q, error_q, overrun_q;
  logic          csum_ok;

  // Edge pulses are registered so every output lands 4 cycles after the pin edge.
  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      irda_s1_q   <= 1'b1;
      irda_s2_q   <= 1'b1;
      irda_prev_q <= 1'b1;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      irda_s1_q   <= ir.i_IRDA;
      irda_s2_q   <= irda_s1_q;
      irda_prev_q <= irda_s2_q;
      rise_q      <= irda_s2_q & ~irda_prev_q;
      fall_q      <= ~irda_s2_q & irda_prev_q;
    end
  end

  assign edge_w    = rise_q | fall_q;
  assign timed_out = (dur_q >= TIMEOUT_CNT);

  // Prescaler counts down to a 1 us tick; both it and the duration restart per edge.
  always_comb begin
    presc_d = presc_q;
    dur_d   = dur_q;
    if (edge_w) begin
      presc_d = PRESC_LOAD;
      dur_d   = '0;
    end else if (presc_q == '0) begin
      presc_d = PRESC_LOAD;
      if (dur_q != 14'h3FFF) dur_d = dur_q + 14'd1;
    end else begin
      presc_d = presc_q - 1'b1;
    end
  end

  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      presc_q <= PRESC_LOAD;
      dur_q   <= '0;
    end else begin
      presc_q <= presc_d;
      dur_q   <= dur_d;
    end
  end

`ifdef NEC_IR_CHECKSUM_EN
  assign csum_ok = (sr_q[15:8] == ~sr_q[7:0]) && (sr_q[31:24] == ~sr_q[23:16]);
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      sr_q         <= '0;
      rep_flag_q   <= 1'b0;
      seen_frame_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      repeat_q     <= 1'b0;
      error_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      error_q  <= 1'b0;
      // Acknowledge first so that an accept later in this block overrides it.
      if (ir.i_DATA_ACK) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (fall_q) state_q <= LEAD_MARK;
        end
        LEAD_MARK: begin
          if (rise_q) begin
            if (in_win(dur_q, LEAD_LO, LEAD_HI)) state_q <= LEAD_SPACE;
            else begin error_q <= 1'b1; state_q <= IDLE; end
          end else if (timed_out) begin
            error_q <= 1'b1; state_q <= IDLE;
          end
        end
        LEAD_SPACE: begin
          if (fall_q) begin
            if (in_win(dur_q, DSPC_LO, DSPC_HI)) begin
              state_q    <= BIT_MARK;
              bit_idx_q  <= '0;
              sr_q       <= '0;
              rep_flag_q <= 1'b0;
            end else if (in_win(dur_q, RSPC_LO, RSPC_HI)) begin
              state_q    <= TRAIL;
              rep_flag_q <= 1'b1;
            end else begin
              error_q <= 1'b1; state_q <= IDLE;
            end
          end else if (timed_out) begin
            error_q <= 1'b1; state_q <= IDLE;
          end
        end
        BIT_MARK: begin
          if (rise_q) begin
            if (in_win(dur_q, SHORT_LO, SHORT_HI)) state_q <= BIT_SPACE;
            else begin error_q <= 1'b1; state_q <= IDLE; end
          end else if (timed_out) begin
            error_q <= 1'b1; state_q <= IDLE;
          end
        end
        BIT_SPACE: begin
          if (fall_q) begin
            if (in_win(dur_q, SHORT_LO, SHORT_HI) || in_win(dur_q, ONE_LO, ONE_HI)) begin
              sr_q[bit_idx_q] <= in_win(dur_q, ONE_LO, ONE_HI);
              if (bit_idx_q == 5'd31) state_q <= TRAIL;
              else begin
                bit_idx_q <= bit_idx_q + 5'd1;
                state_q   <= BIT_MARK;
              end
            end else begin
              error_q <= 1'b1; state_q <= IDLE;
            end
          end else if (timed_out) begin
            error_q <= 1'b1; state_q <= IDLE;
          end
        end
        TRAIL: begin
          if (rise_q) begin
            state_q <= IDLE;
            if (!in_win(dur_q, SHORT_LO, SHORT_HI)) error_q <= 1'b1;
            else if (rep_flag_q) repeat_q <= seen_frame_q;
            else if (!csum_ok) error_q <= 1'b1;
            else begin
              data_q       <= sr_q;
              valid_q      <= 1'b1;
              seen_frame_q <= 1'b1;
              // Overrun is sticky: it can only be set while valid is high.
              overrun_q    <= valid_q & ~ir.i_DATA_ACK;
            end
          end else if (timed_out) begin
            error_q <= 1'b1; state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ir.o_DATA       = data_q;
  assign ir.o_DATA_VALID = valid_q;
  assign ir.o_REPEAT     = repeat_q;
  assign ir.o_ERROR      = error_q;
  assign ir.o_OVERRUN    = overrun_q;

endmodule

// File: tb/tb_nec_ir_decoder.sv
module tb_nec_ir_decoder;
  localparam int EV_DATA = 0;
  localparam int EV_REP  = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;
  int   cyc;
  int   evt_cyc;
  int   last_rise_cyc;
  int   last_fall_cyc;
  ev_t  exp_q[$];

  nec_ir_decoder_if ir ();

  nec_ir_decoder #(
    .CLK_HZ(1_000_000),
    .TOL_PCT(20),
    .TIMEOUT_US(12_000)
  ) dut (
    .i_CLOCK_POS(clk),
    .i_RESET_NEG(rst_n),
    .ir(ir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, run=%0d failed=%0d", n_run, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic got(input int kind, input logic [31:0] data);
    ev_t e;
    evt_cyc = cyc;
    if (exp_q.size() == 0) begin
      n_run++;
      n_fail++;
      $error("FAIL sb_unexpected: observed kind=%0d data=0x%08h expected no event (cyc %0d)",
             kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 64'(kind), 64'(e.kind));
      if (e.kind == EV_DATA) check("sb_data", {32'd0, data}, {32'd0, e.data});
    end
  endtask

  // Output monitor: turns output activity into scoreboard events.
  initial begin
    logic        valid_prev;
    logic [31:0] data_prev;
    valid_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ir.o_DATA_VALID && (!valid_prev || ir.o_DATA != data_prev)) got(EV_DATA, ir.o_DATA);
        if (ir.o_REPEAT) got(EV_REP, 32'd0);
        if (ir.o_ERROR)  got(EV_ERR, 32'd0);
      end
      valid_prev = ir.o_DATA_VALID;
      data_prev  = ir.o_DATA;
    end
  end

  task automatic push(input int kind, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Drive a level for n microseconds (1 cycle = 1 us); always starts on a negedge.
  task automatic lvl(input logic v, input int n);
    if (ir.i_IRDA !== v) begin
      if (v) last_rise_cyc = cyc;
      else   last_fall_cyc = cyc;
    end
    ir.i_IRDA = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] d, input int pct, input int bad_bit);
    lvl(1'b0, 9000 * pct / 100);
    lvl(1'b1, 4500 * pct / 100);
    for (int i = 0; i < 32; i++) begin
      lvl(1'b0, 560 * pct / 100);
      if (i == bad_bit) lvl(1'b1, 1200);
      else              lvl(1'b1, (d[i] ? 1690 : 560) * pct / 100);
    end
    lvl(1'b0, 560 * pct / 100);
    lvl(1'b1, 0);
  endtask

  task automatic send_repeat();
    lvl(1'b0, 9000);
    lvl(1'b1, 2250);
    lvl(1'b0, 560);
    lvl(1'b1, 0);
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic ack_pulse();
    ir.i_DATA_ACK = 1'b1;
    @(negedge clk);
    ir.i_DATA_ACK = 1'b0;
  endtask

  initial begin
    logic [31:0] part;
    int          dt;
    n_run = 0;
    n_fail = 0;
    cyc = 0;
    evt_cyc = 0;
    last_rise_cyc = 0;
    last_fall_cyc = 0;
    ir.i_IRDA = 1'b1;
    ir.i_DATA_ACK = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data", {32'd0, ir.o_DATA}, 64'd0);
    check("rst_valid", 64'(ir.o_DATA_VALID), 64'd0);
    check("rst_repeat", 64'(ir.o_REPEAT), 64'd0);
    check("rst_error", 64'(ir.o_ERROR), 64'd0);
    check("rst_overrun", 64'(ir.o_OVERRUN), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Repeat before any frame: silently ignored.
    send_repeat();
    lvl(1'b1, 50);
    check("rep_nofrm_valid", 64'(ir.o_DATA_VALID), 64'd0);
    check("rep_nofrm_data", {32'd0, ir.o_DATA}, 64'd0);

    // Nominal frame addr 0x00 cmd 0x45.
    push(EV_DATA, 32'hBA45_FF00);
    send_frame(32'hBA45_FF00, 100, -1);
    wait_drain("drain_nominal", 20);
    check("valid_latency", 64'(evt_cyc - last_rise_cyc), 64'd4);
    lvl(1'b1, 50);
    check("valid_held", 64'(ir.o_DATA_VALID), 64'd1);
    check("nominal_overrun", 64'(ir.o_OVERRUN), 64'd0);
    ack_pulse();
    check("ack_clr_valid", 64'(ir.o_DATA_VALID), 64'd0);

    // Repeat after an accepted frame.
    push(EV_REP, 32'd0);
    send_repeat();
    wait_drain("drain_repeat", 20);
    check("repeat_latency", 64'(evt_cyc - last_rise_cyc), 64'd4);
    check("repeat_data_kept", {32'd0, ir.o_DATA}, 64'h0000_0000_BA45_FF00);
    check("repeat_no_valid", 64'(ir.o_DATA_VALID), 64'd0);
    lvl(1'b1, 50);

    // All durations +15%.
    push(EV_DATA, 32'hBA45_FF00);
    send_frame(32'hBA45_FF00, 115, -1);
    wait_drain("drain_slow", 20);
    check("slow_valid", 64'(ir.o_DATA_VALID), 64'd1);
    ack_pulse();
    lvl(1'b1, 50);

    // Last space 1200 us: out of both bit windows.
    push(EV_ERR, 32'd0);
    send_frame(32'hBA45_FF00, 100, 31);
    wait_drain("drain_bad", 20);
    check("error_latency", 64'(evt_cyc - last_fall_cyc), 64'd4);
    lvl(1'b1, 100);
    check("bad_no_valid", 64'(ir.o_DATA_VALID), 64'd0);
    check("bad_data_kept", {32'd0, ir.o_DATA}, 64'h0000_0000_BA45_FF00);

    // Two frames without ack -> overrun.
    push(EV_DATA, 32'hBA45_FF00);
    send_frame(32'hBA45_FF00, 100, -1);
    wait_drain("drain_f1", 20);
    check("f1_overrun", 64'(ir.o_OVERRUN), 64'd0);
    lvl(1'b1, 100);
    push(EV_DATA, 32'hB946_FF00);
    send_frame(32'hB946_FF00, 100, -1);
    wait_drain("drain_f2", 20);
    check("f2_data", {32'd0, ir.o_DATA}, 64'h0000_0000_B946_FF00);
    check("f2_valid", 64'(ir.o_DATA_VALID), 64'd1);
    check("f2_overrun", 64'(ir.o_OVERRUN), 64'd1);
    ack_pulse();
    check("ack_clr_valid2", 64'(ir.o_DATA_VALID), 64'd0);
    check("ack_clr_overrun", 64'(ir.o_OVERRUN), 64'd0);
    lvl(1'b1, 100);

    // Lead mark held 13 ms -> timeout error around 12 000 us.
    push(EV_ERR, 32'd0);
    lvl(1'b0, 13_000);
    lvl(1'b1, 100);
    wait_drain("drain_timeout", 20);
    dt = evt_cyc - last_fall_cyc;
    check("timeout_window", 64'((dt >= 11_995) && (dt <= 12_010)), 64'd1);

    // Reset during bit 10 of a frame.
    part = 32'hBA45_FF00;
    lvl(1'b0, 9000);
    lvl(1'b1, 4500);
    for (int i = 0; i < 10; i++) begin
      lvl(1'b0, 560);
      lvl(1'b1, part[i] ? 1690 : 560);
    end
    lvl(1'b0, 560);
    lvl(1'b1, 100);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_data", {32'd0, ir.o_DATA}, 64'd0);
    check("midrst_valid", 64'(ir.o_DATA_VALID), 64'd0);
    check("midrst_error", 64'(ir.o_ERROR), 64'd0);
    rst_n = 1'b1;
    lvl(1'b1, 13_000);
    check("midrst_no_events", 64'(exp_q.size()), 64'd0);
    check("midrst_valid_after", 64'(ir.o_DATA_VALID), 64'd0);

    // Frame whose bytes are not complementary.
`ifdef NEC_IR_CHECKSUM_EN
    push(EV_ERR, 32'd0);
`else
    push(EV_DATA, 32'h0045_FF00);
`endif
    send_frame(32'h0045_FF00, 100, -1);
    wait_drain("drain_csum", 20);
    lvl(1'b1, 50);
`ifdef NEC_IR_CHECKSUM_EN
    check("csum_valid", 64'(ir.o_DATA_VALID), 64'd0);
    check("csum_data", {32'd0, ir.o_DATA}, 64'd0);
`else
    check("csum_valid", 64'(ir.o_DATA_VALID), 64'd1);
    check("csum_data", {32'd0, ir.o_DATA}, 64'h0000_0000_0045_FF00);
`endif
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
